// File: rtl/div_req_scheduler.sv
// Round-robin scheduler that time-shares one unsigned divider core between NREQ
// requesters, resolving divide-by-zero locally and guarding each job with a watchdog.
module div_req_scheduler #(
    parameter int  NREQ    = 4,
    parameter int  WID     = 4,
    parameter int  TIMEOUT = 16,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NREQ-1:0]     i_req_valid,
    input  logic [NREQ*WID-1:0] i_req_dividend,
    input  logic [NREQ*WID-1:0] i_req_divisor,
    output logic [NREQ-1:0]     o_req_ready,
    output logic                o_div_start,
    output logic [WID-1:0]      o_div_dividend,
    output logic [WID-1:0]      o_div_divisor,
    output logic                o_div_abort,
    input  logic                i_div_done,
    input  logic [WID-1:0]      i_div_quot,
    input  logic [WID-1:0]      i_div_rem,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [IDW-1:0]      o_rsp_id,
    output logic [WID-1:0]      o_rsp_quot,
    output logic [WID-1:0]      o_rsp_rem,
    output logic [1:0]          o_rsp_err,
    output logic [1:0]          o_state
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] ISSUE = 2'b01;
    localparam logic [1:0] WAIT  = 2'b10;
    localparam logic [1:0] RESP  = 2'b11;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_DIV0    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IDW-1:0] IDX_LAST = IDW'(NREQ - 1);

    logic [1:0]     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IDW-1:0] id_q, id_d;
    logic [WID-1:0] dvd_q, dvd_d;
    logic [WID-1:0] dvs_q, dvs_d;
    logic [WID-1:0] quot_q, quot_d;
    logic [WID-1:0] rem_q, rem_d;
    logic [1:0]     err_q, err_d;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic           accept;
    logic           timeout_hit;
    logic [WID-1:0] sel_dividend;
    logic [WID-1:0] sel_divisor;

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        wrap_idx = IDW'((int'(base) + off) % NREQ);
    endfunction

    // Search starts at the pointer and wraps, so the first valid hit is the round-robin winner.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && i_req_valid[wrap_idx(ptr_q, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_idx(ptr_q, k);
            end
        end
    end

    assign accept = (state_q == IDLE) && grant_found && !i_rst;

    always_comb begin
        o_req_ready  = '0;
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == IDW'(k)) begin
                o_req_ready[k] = accept;
                sel_dividend   = i_req_dividend[k*WID +: WID];
                sel_divisor    = i_req_divisor[k*WID +: WID];
            end
        end
    end

    // A done pulse on the last watchdog cycle still counts as completion.
    assign timeout_hit = (state_q == WAIT) && !i_div_done && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d  = grant_idx;
                    dvd_d = sel_dividend;
                    dvs_d = sel_divisor;
                    ptr_d = (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
                    if (sel_divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = sel_dividend;
                        err_d   = ERR_DIV0;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (i_div_done) begin
                    quot_d  = i_div_quot;
                    rem_d   = i_div_rem;
                    err_d   = ERR_OK;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    quot_d  = '0;
                    rem_d   = '0;
                    err_d   = ERR_TIMEOUT;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    // Pulses are masked during reset so an abandoned job never starts or aborts the core.
    assign o_div_start    = (state_q == ISSUE) && !i_rst;
    assign o_div_abort    = timeout_hit && !i_rst;
    assign o_div_dividend = dvd_q;
    assign o_div_divisor  = dvs_q;
    assign o_rsp_valid    = (state_q == RESP);
    assign o_rsp_id       = id_q;
    assign o_rsp_quot     = quot_q;
    assign o_rsp_rem      = rem_q;
    assign o_rsp_err      = err_q;
    assign o_state        = state_q;

endmodule

// File: tb/tb_div_req_scheduler.sv
// Scoreboard bench for div_req_scheduler: directed jobs push expected responses,
// a monitor pops and compares on every response handshake.
module tb_div_req_scheduler;

    localparam int NREQ    = 4;
    localparam int WID     = 4;
    localparam int TIMEOUT = 16;
    localparam int IDW     = 2;

    typedef logic [IDW+2*WID+1:0] rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NREQ-1:0]     reqValid;
    logic [NREQ*WID-1:0] reqDividend;
    logic [NREQ*WID-1:0] reqDivisor;
    logic [NREQ-1:0]     reqReady;
    logic                divStart;
    logic [WID-1:0]      divDividend;
    logic [WID-1:0]      divDivisor;
    logic                divAbort;
    logic                divDone;
    logic [WID-1:0]      divQuot;
    logic [WID-1:0]      divRem;
    logic                rspValid;
    logic                rspReady;
    logic [IDW-1:0]      rspId;
    logic [WID-1:0]      rspQuot;
    logic [WID-1:0]      rspRem;
    logic [1:0]          rspErr;
    logic [1:0]          state;

    div_req_scheduler #(.NREQ(NREQ), .WID(WID), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(reqValid), .i_req_dividend(reqDividend), .i_req_divisor(reqDivisor),
        .o_req_ready(reqReady),
        .o_div_start(divStart), .o_div_dividend(divDividend), .o_div_divisor(divDivisor),
        .o_div_abort(divAbort),
        .i_div_done(divDone), .i_div_quot(divQuot), .i_div_rem(divRem),
        .o_rsp_valid(rspValid), .i_rsp_ready(rspReady),
        .o_rsp_id(rspId), .o_rsp_quot(rspQuot), .o_rsp_rem(rspRem), .o_rsp_err(rspErr),
        .o_state(state)
    );

    // Core model: done arrives coreLat cycles after the start pulse unless coreHang is set.
    bit             coreHang = 1'b0;
    int             coreLat = 5;
    logic           modelBusy, modelDone;
    int             modelCnt;
    logic [WID-1:0] opA, opB, modelQuot, modelRem;
    logic           injDone;
    logic [WID-1:0] injQuot, injRem;

    assign divDone = modelDone | injDone;
    assign divQuot = injDone ? injQuot : modelQuot;
    assign divRem  = injDone ? injRem : modelRem;

    always @(posedge clk) begin
        if (rst) begin
            modelBusy <= 1'b0;
            modelDone <= 1'b0;
            modelCnt  <= 0;
            modelQuot <= '0;
            modelRem  <= '0;
        end else begin
            modelDone <= 1'b0;
            if (divStart) begin
                modelBusy <= 1'b1;
                modelCnt  <= 1;
                opA       <= divDividend;
                opB       <= divDivisor;
            end else if (modelBusy) begin
                if (modelCnt == coreLat - 1) begin
                    modelBusy <= 1'b0;
                    if (!coreHang) begin
                        modelDone <= 1'b1;
                        modelQuot <= (opB != 0) ? opA / opB : '1;
                        modelRem  <= (opB != 0) ? opA % opB : opA;
                    end
                end else begin
                    modelCnt <= modelCnt + 1;
                end
            end
        end
    end

    // Requesters hold valid until they have been granted targetCnt times.
    int targetCnt [NREQ];
    int grantCnt [NREQ];
    int grantLog [$];

    always_comb begin
        reqValid = '0;
        for (int i = 0; i < NREQ; i++) reqValid[i] = (grantCnt[i] < targetCnt[i]);
    end

    always @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (reqReady[i] === 1'b1) begin
                grantCnt[i] <= grantCnt[i] + 1;
                grantLog.push_back(i);
            end
        end
    end

    int   vectors = 0;
    int   miscompares = 0;
    rsp_t expQ [$];

    logic [1:0]      trState [64];
    logic            trStart [64];
    logic            trAbort [64];
    logic            trRspValid [64];
    logic [NREQ-1:0] trReady [64];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int r, input int dvd, input int dvs, input int n);
        reqDividend[r*WID +: WID] = WID'(dvd);
        reqDivisor[r*WID +: WID]  = WID'(dvs);
        targetCnt[r] += n;
    endtask

    task automatic expectRsp(input int id, input int q, input int r, input int e);
        rsp_t x;
        x = {IDW'(id), WID'(q), WID'(r), 2'(e)};
        expQ.push_back(x);
    endtask

    task automatic monitor();
        rsp_t exp;
        forever begin
            @(negedge clk);
            checkOutput("ready_onehot", 32'(reqReady & (reqReady - 1'b1)), 32'd0);
            if (rspValid && rspReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("rsp_unexpected", 32'({rspId, rspQuot, rspRem, rspErr}), 32'hFFFF_FFFF);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("rsp", 32'({rspId, rspQuot, rspRem, rspErr}), 32'(exp));
                end
            end
        end
    endtask

    task automatic traceCycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            trState[c]    = state;
            trStart[c]    = divStart;
            trAbort[c]    = divAbort;
            trRspValid[c] = rspValid;
            trReady[c]    = reqReady;
        end
    endtask

    task automatic syncStep();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int maxCycles);
        for (int c = 0; c < maxCycles; c++) begin
            syncStep();
            if (expQ.size() == 0 && state == 2'b00) break;
        end
        checkOutput(name, 32'(expQ.size()), 32'd0);
    endtask

    task automatic waitForState(input string name, input logic [1:0] s, input int maxCycles);
        for (int c = 0; c < maxCycles; c++) begin
            @(negedge clk);
            if (state == s) break;
        end
        checkOutput(name, 32'(state), 32'(s));
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   nReady, nStart, nAbort, base;
        logic [1:0] es;

        rst = 1'b1;
        rspReady = 1'b1;
        injDone = 1'b0;
        injQuot = '0;
        injRem = '0;
        reqDividend = '0;
        reqDivisor = '0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs",
            32'({state, reqReady, divStart, divDividend, divDivisor, divAbort,
                 rspValid, rspId, rspQuot, rspRem, rspErr}), 32'd0);
        rst = 1'b0;

        $display("[TB] test 1: 15/2 from requester 0");
        applyStimulus(0, 15, 2, 1);
        expectRsp(0, 7, 1, 0);
        traceCycles(9);
        nReady = 0;
        nStart = 0;
        for (int c = 0; c < 9; c++) begin
            es = (c == 0) ? 2'd0 : (c == 1) ? 2'd1 : (c <= 6) ? 2'd2 : (c == 7) ? 2'd3 : 2'd0;
            checkOutput($sformatf("t1_state_c%0d", c), 32'(trState[c]), 32'(es));
            if (trReady[c] != 0) nReady++;
            if (trStart[c]) nStart++;
        end
        checkOutput("t1_ready_c0", 32'(trReady[0]), 32'b0001);
        checkOutput("t1_ready_pulses", 32'(nReady), 32'd1);
        checkOutput("t1_start_c1", 32'(trStart[1]), 32'd1);
        checkOutput("t1_start_pulses", 32'(nStart), 32'd1);

        syncStep();
        rst = 1'b1;
        syncStep();
        rst = 1'b0;

        $display("[TB] test 2: requesters 0 and 2 contend");
        base = grantLog.size();
        applyStimulus(0, 8, 3, 2);
        applyStimulus(2, 13, 4, 2);
        expectRsp(0, 2, 2, 0);
        expectRsp(2, 3, 1, 0);
        expectRsp(0, 2, 2, 0);
        expectRsp(2, 3, 1, 0);
        drain("t2_drain", 200);
        checkOutput("t2_grant_count", 32'(grantLog.size() - base), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (base + k < grantLog.size())
                checkOutput($sformatf("t2_grant_%0d", k), 32'(grantLog[base+k]), (k % 2 == 0) ? 32'd0 : 32'd2);
        end

        $display("[TB] test 3: 9/0 from requester 1");
        applyStimulus(1, 9, 0, 1);
        expectRsp(1, 15, 9, 1);
        traceCycles(3);
        checkOutput("t3_ready_c0", 32'(trReady[0]), 32'b0010);
        checkOutput("t3_state_c1", 32'(trState[1]), 32'd3);
        checkOutput("t3_valid_seq", 32'({trRspValid[0], trRspValid[1], trRspValid[2]}), 32'b010);
        checkOutput("t3_no_start", 32'({trStart[0], trStart[1], trStart[2]}), 32'd0);

        $display("[TB] test 4: core hangs, watchdog fires");
        syncStep();
        coreHang = 1'b1;
        applyStimulus(3, 7, 3, 1);
        expectRsp(3, 0, 0, 2);
        traceCycles(20);
        for (int c = 0; c < 20; c++) begin
            es = (c == 0) ? 2'd0 : (c == 1) ? 2'd1 : (c <= 17) ? 2'd2 : (c == 18) ? 2'd3 : 2'd0;
            checkOutput($sformatf("t4_state_c%0d", c), 32'(trState[c]), 32'(es));
            checkOutput($sformatf("t4_abort_c%0d", c), 32'(trAbort[c]), (c == 17) ? 32'd1 : 32'd0);
        end
        coreHang = 1'b0;

        $display("[TB] test 4b: done on the last watchdog cycle");
        syncStep();
        coreLat = 16;
        applyStimulus(1, 14, 3, 1);
        expectRsp(1, 4, 2, 0);
        traceCycles(20);
        nAbort = 0;
        for (int c = 0; c < 20; c++) if (trAbort[c]) nAbort++;
        checkOutput("t4b_no_abort", 32'(nAbort), 32'd0);
        checkOutput("t4b_state_c17", 32'(trState[17]), 32'd2);
        checkOutput("t4b_state_c18", 32'(trState[18]), 32'd3);
        coreLat = 5;

        $display("[TB] test 5: response backpressure");
        syncStep();
        rspReady = 1'b0;
        applyStimulus(0, 12, 5, 1);
        applyStimulus(1, 5, 1, 1);
        applyStimulus(2, 6, 4, 1);
        expectRsp(2, 1, 2, 0);
        expectRsp(0, 2, 2, 0);
        expectRsp(1, 5, 0, 0);
        waitForState("t5_reach_resp", 2'd3, 40);
        for (int h = 0; h < 5; h++) begin
            if (h > 0) @(negedge clk);
            checkOutput($sformatf("t5_hold_fields_%0d", h),
                32'({rspValid, rspId, rspQuot, rspRem, rspErr}), 32'({1'b1, 2'd2, 4'd1, 4'd2, 2'd0}));
            checkOutput($sformatf("t5_hold_ready_%0d", h), 32'(reqReady), 32'd0);
        end
        syncStep();
        rspReady = 1'b1;
        @(negedge clk);
        checkOutput("t5_release_state", 32'(state), 32'd3);
        @(negedge clk);
        checkOutput("t5_resume_state", 32'(state), 32'd0);
        checkOutput("t5_resume_ready", 32'(reqReady), 32'b0001);
        drain("t5_drain", 100);

        $display("[TB] test 6: reset in WAIT");
        coreHang = 1'b1;
        applyStimulus(2, 10, 3, 1);
        waitForState("t6_reach_wait", 2'd2, 20);
        repeat (3) @(negedge clk);
        syncStep();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6_rst_cycle", 32'({reqReady, divStart, divAbort}), 32'd0);
        syncStep();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t6_after_reset",
            32'({state, reqReady, divStart, divDividend, divDivisor, divAbort,
                 rspValid, rspId, rspQuot, rspRem, rspErr}), 32'd0);
        syncStep();
        injDone = 1'b1;
        injQuot = 4'd5;
        injRem  = 4'd1;
        syncStep();
        injDone = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput($sformatf("t6_idle_%0d", c), 32'({state, rspValid}), 32'd0);
        end
        coreHang = 1'b0;
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_req_scheduler.md
Name: div_req_scheduler

Overview:
- Shares one unsigned restoring-divider core between NREQ requesters. Arbitration is round-robin.
- Sequences the core for each job:
  - latches the winner's operands;
  - pulses the core start;
  - waits for core done, guarded by a watchdog timeout;
  - returns quotient and remainder with the requester ID.
- Sits between the requesting units and the divider top level.
- Divide-by-zero is resolved locally and never reaches the core.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WID, 4, operand, quotient and remainder width.
- TIMEOUT, 16, cycles allowed in WAIT before the job is aborted (must be > WID+2).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req_valid  in  NREQ  per-requester job valid.
- i_req_dividend  in  NREQ*WID  flattened; slice i = [i*WID +: WID].
- i_req_divisor  in  NREQ*WID  flattened, same slicing as dividend.
- o_req_ready  out  NREQ  one-hot accept, combinational.
- o_div_start  out  1  one-cycle start pulse to the core.
- o_div_dividend  out  WID  latched dividend to the core.
- o_div_divisor  out  WID  latched divisor to the core.
- o_div_abort  out  1  one-cycle pulse on timeout.
- i_div_done  in  1  core completion pulse.
- i_div_quot  in  WID  core quotient.
- i_div_rem  in  WID  core remainder.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response accept.
- o_rsp_id  out  clog2(NREQ)  index of the requester that owns the response.
- o_rsp_quot  out  WID  response quotient.
- o_rsp_rem  out  WID  response remainder.
- o_rsp_err  out  2  00 ok, 01 divide-by-zero, 10 timeout.
- o_state  out  2  current state: IDLE=00, ISSUE=01, WAIT=10, RESP=11.

Behaviour:
- Reset:
  - State goes to IDLE; round-robin pointer goes to 0.
  - Watchdog counter goes to 0.
  - All outputs are 0.
  - Reset in any state, including mid-WAIT, abandons the job and produces no response and no abort pulse. The core shares i_rst.
- IDLE:
  - Winner = first index at or after the pointer, modulo NREQ, with i_req_valid set.
  - o_req_ready[winner]=1 combinationally. All ready bits are 0 outside IDLE or when no request is valid.
  - On accept:
    - latch dividend, divisor and id;
    - pointer = (winner+1) mod NREQ;
    - if divisor == 0, go to RESP with quot = all ones, rem = dividend, err = 01;
    - otherwise go to ISSUE.
- ISSUE: o_div_start=1 for exactly this cycle; counter cleared; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - If i_div_done=1: capture i_div_quot and i_div_rem, err = 00, go to RESP.
  - Else if counter == TIMEOUT-1: o_div_abort=1 for this cycle, quot = 0, rem = 0, err = 10, go to RESP.
  - Done and timeout in the same cycle: done wins.
- RESP:
  - o_rsp_valid=1. All o_rsp_* fields are held stable until i_rsp_ready=1 samples high.
  - Then go to IDLE. The next job can be accepted in the following cycle, never the same cycle.
- i_div_done outside WAIT is ignored.
- o_div_dividend and o_div_divisor hold the latched values from accept until the next accept.
- Latency, with accept at edge 0:
  - start high in cycle 1;
  - core done seen in cycle k gives rsp_valid from cycle k+1;
  - divide-by-zero gives rsp_valid in cycle 1.
- Throughput: one job in flight; no queuing.
- Requesters hold valid and operands stable until ready.

Test Plan:
- WID=4, requester 0 presents 15/2, core model done 5 cycles after start:
  - one o_req_ready[0] pulse, then one o_div_start pulse;
  - rsp id=0, quot=0111, rem=0001, err=00;
  - o_state sequence 00,01,10...,11,00.
- Requesters 0 and 2 both held valid, pointer 0:
  - grants in order 0, 2, 0, 2;
  - never two ready bits high in the same cycle.
- Requester 1 presents 9/0:
  - o_div_start never asserted;
  - rsp_valid the cycle after accept, quot=1111, rem=1001, err=01.
- Core model never asserts done, TIMEOUT=16:
  - o_div_abort pulses in cycle 16 after start;
  - rsp err=10, quot=0000, rem=0000.
- i_rsp_ready held low 5 cycles with other requests valid:
  - rsp fields stable;
  - all o_req_ready low;
  - accept resumes the cycle after IDLE is re-entered.
- i_rst asserted mid-WAIT:
  - next cycle state 00, all outputs 0;
  - no response for the abandoned job;
  - a late i_div_done is ignored.
